eth_phy_10g_tx_if: RTL and testbench
====================================

Name: eth_phy_10g_tx_if

Overview:
Transmit-side PHY interface for the 10GBASE-R path. It accepts 64b/66b encoded blocks from the MAC encoder, applies the self-synchronous scrambler or the PRBS31 test pattern, optionally bit-reverses, and registers the result toward the SERDES. It pairs with the RX PHY interface (descrambler, block lock, BER) and sits between axis_baser_tx_64 and the transceiver TX port.

Parameters:
DATA_WIDTH, 64, encoded data width; only 64 is legal (elaboration error otherwise)
HDR_WIDTH, 2, sync header width; must equal DATA_WIDTH/32 (elaboration error otherwise)
BIT_REVERSE, 0, 1 = reverse bit order of data[63:0] and hdr[1:0] at the output
SCRAMBLER_DISABLE, 0, 1 = data passes unscrambled; scrambler state is held at its reset value
PRBS31_ENABLE, 0, 1 = instantiate the PRBS31 generator; 0 = tx_prbs31_enable is ignored
SERDES_PIPELINE, 0, number of extra register stages after the output register (0..4)

Ports:
clk  input  1  TX clock, one 66b block per cycle
rst_n  input  1  reset; asynchronous assert, active-low
encoded_tx_data  input  64  encoded block payload, bit 0 transmitted first
encoded_tx_hdr  input  2  sync header: 2'b01 data, 2'b10 control
serdes_tx_data  output  64  scrambled payload to SERDES
serdes_tx_hdr  output  2  sync header to SERDES, never scrambled
tx_bad_block  output  1  one-cycle pulse, aligned with the output of a block whose input header was 2'b00 or 2'b11
tx_prbs31_enable  input  1  select PRBS31 test pattern (quasi-static)

Behaviour:
- Reset: the async clear sets all registers; serdes_tx_data=0, serdes_tx_hdr=0, tx_bad_block=0, scrambler state=58'h3FF_FFFF_FFFF_FFFF, PRBS state=31'h7FFF_FFFF, all pipeline stages=0. Reset deassertion mid-stream restarts from these values. No partial block is ever emitted.
- Latency: input to output = 1 + SERDES_PIPELINE cycles. There is no backpressure; one block is accepted every cycle.
- Scrambler (x^58+x^39+1), applied serially from bit 0 to bit 63 within one cycle:
  - out[j] = in[j] ^ s[38] ^ s[57]
  - then s = {s[56:0], out[j]}
  - The header bypasses the scrambler. The state carries across cycles.
- PRBS31 (x^31+x^28+1), active when PRBS31_ENABLE and tx_prbs31_enable:
  - 66 bits are generated per cycle: n = s[30]^s[27]; s = {s[29:0], n}
  - Output bit = ~n. Bits 0-1 go to hdr[1:0]; bits 2-65 go to data[63:0].
  - Input data and header are ignored.
  - The scrambler keeps running on the input while PRBS is selected, so switching back needs no re-seed.
- Switching tx_prbs31_enable takes effect on the next accepted block; there is no glitch or partial block.
- tx_bad_block: combinational check of the input header, registered and pipelined with the data. It is forced 0 in PRBS mode. The illegal header is still forwarded unchanged.
- Bit reverse: applied after scramble/PRBS selection and before the output register.
- SERDES_PIPELINE stages: plain registers, cleared by reset. data, hdr and tx_bad_block are delayed identically.

Decomposition:
- Shared package eth_phy_10g_pkg holds:
  - header constants SYNC_DATA=2'b01, SYNC_CTRL=2'b10
  - SCRAMBLER_INIT=58'h3FF_FFFF_FFFF_FFFF, PRBS31_INIT=31'h7FFF_FFFF
  - tap indices 38/57 and 27/30
- One natural sub-module: lfsr_step, a parameterised combinational LFSR advance (width, taps, bits per step, feed-forward/self-sync mode). It is reused for both the scrambler and PRBS31 and later by the RX descrambler.

Test Plan:
- SCRAMBLER_DISABLE=1, BIT_REVERSE=0: drive data 64'h0123_4567_89AB_CDEF, hdr 2'b01. Output is identical after exactly 1 cycle; tx_bad_block=0.
- Scrambler from reset with data 64'h0, hdr 2'b10: first output word has bits[38:0]=0 and bit 39=1, hdr=2'b10. A 1000-block random stream looped through a golden descrambler matches the input bit-exact.
- Illegal header: drive hdr 2'b00, then 2'b11, then 2'b01. tx_bad_block pulses high for the first two output cycles only, and both headers appear unchanged on serdes_tx_hdr.
- PRBS31_ENABLE=1, assert tx_prbs31_enable: 10,000 output blocks (hdr+data as a 66b stream) self-check with a PRBS31 checker, 0 errors. Deasserting it resumes scrambled traffic the next block, and that traffic descrambles correctly.
- SERDES_PIPELINE=3, BIT_REVERSE=1: input 64'h1, hdr 2'b01 produces output 64'h8000_0000_0000_0000, hdr 2'b10, after 4 cycles.
- Assert rst_n low asynchronously mid-stream (between clock edges): outputs go to 0 immediately. After release, the first scrambled block of all-zero data again shows bits[38:0]=0 and bit 39=1.

Source files
------------

// File: rtl/eth_phy_10g_pkg.sv
// Shared constants and types for the 10GBASE-R PHY TX/RX interfaces.
// Holds sync headers, LFSR seeds, tap positions and the registered beat layout.
// No logic of its own; imported by every PHY interface module.
package eth_phy_10g_pkg;

    localparam logic [1:0]  SYNC_DATA      = 2'b01;
    localparam logic [1:0]  SYNC_CTRL      = 2'b10;

    localparam logic [57:0] SCRAMBLER_INIT = 58'h3FF_FFFF_FFFF_FFFF;
    localparam logic [30:0] PRBS31_INIT    = 31'h7FFF_FFFF;

    localparam int SCR_TAP_A  = 38;
    localparam int SCR_TAP_B  = 57;
    localparam int PRBS_TAP_A = 27;
    localparam int PRBS_TAP_B = 30;

    typedef enum logic [1:0] {
        LFSR_SCRAMBLE,
        LFSR_DESCRAMBLE,
        LFSR_PRBS
    } lfsr_mode_t;

    typedef struct packed {
        logic        bad;
        logic [1:0]  hdr;
        logic [63:0] data;
    } tx_beat_t;

    function automatic logic hdr_is_bad(input logic [1:0] hdr);
        return !((hdr == SYNC_DATA) || (hdr == SYNC_CTRL));
    endfunction

endpackage

// File: rtl/eth_phy_10g_lfsr_step.sv
// Combinational multi-bit advance of a two-tap LFSR (scramble, descramble or PRBS).
// Latency: 0 cycles, pure combinational; bit 0 of data is processed first.
// Backpressure: none; the caller decides when to commit state_out.
module lfsr_step
    import eth_phy_10g_pkg::*;
#(
    parameter int         WIDTH = 58,
    parameter int         TAP_A = 38,
    parameter int         TAP_B = 57,
    parameter int         NBITS = 64,
    parameter lfsr_mode_t MODE  = LFSR_SCRAMBLE
) (
    input  logic [WIDTH-1:0] state_in,
    input  logic [NBITS-1:0] data_in,
    output logic [WIDTH-1:0] state_out,
    output logic [NBITS-1:0] data_out
);

    logic [WIDTH-1:0] s;
    logic             fb;

    // In PRBS mode data_in acts as an XOR mask on the generated stream.
    always_comb begin
        s        = state_in;
        fb       = 1'b0;
        data_out = '0;
        for (int j = 0; j < NBITS; j++) begin
            fb = s[TAP_A] ^ s[TAP_B];
            case (MODE)
                LFSR_SCRAMBLE: begin
                    data_out[j] = data_in[j] ^ fb;
                    s           = {s[WIDTH-2:0], data_out[j]};
                end
                LFSR_DESCRAMBLE: begin
                    data_out[j] = data_in[j] ^ fb;
                    s           = {s[WIDTH-2:0], data_in[j]};
                end
                default: begin
                    data_out[j] = data_in[j] ^ ~fb;
                    s           = {s[WIDTH-2:0], fb};
                end
            endcase
        end
        state_out = s;
    end

endmodule

// File: rtl/eth_phy_10g_tx_if.sv
// 10GBASE-R TX PHY interface: scrambles or replaces with PRBS31, bit-reverses, registers to SERDES.
// Latency: 1 + SERDES_PIPELINE cycles from encoded_tx_* to serdes_tx_*.
// Backpressure: none; one 66b block is accepted every clock.
module eth_phy_10g_tx_if
    import eth_phy_10g_pkg::*;
#(
    parameter int DATA_WIDTH        = 64,
    parameter int HDR_WIDTH         = 2,
    parameter int BIT_REVERSE       = 0,
    parameter int SCRAMBLER_DISABLE = 0,
    parameter int PRBS31_ENABLE     = 0,
    parameter int SERDES_PIPELINE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] encoded_tx_data,
    input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
    output logic [DATA_WIDTH-1:0] serdes_tx_data,
    output logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
    output logic                  tx_bad_block,
    input  logic                  tx_prbs31_enable
);

    if (DATA_WIDTH != 64) begin : g_bad_data_width
        $error("eth_phy_10g_tx_if: DATA_WIDTH must be 64");
    end
    if (HDR_WIDTH != DATA_WIDTH / 32) begin : g_bad_hdr_width
        $error("eth_phy_10g_tx_if: HDR_WIDTH must equal DATA_WIDTH/32");
    end
    if (SERDES_PIPELINE < 0 || SERDES_PIPELINE > 4) begin : g_bad_pipeline
        $error("eth_phy_10g_tx_if: SERDES_PIPELINE must be 0..4");
    end

    logic [57:0] scr_state;
    logic [57:0] scr_next;
    logic [63:0] scr_data;
    logic [30:0] prbs_state;
    logic [30:0] prbs_next;
    logic [65:0] prbs_bits;
    logic        prbs_sel;
    tx_beat_t    beat_mux;
    tx_beat_t    beat_d;
    tx_beat_t    beat_q;

    assign prbs_sel = (PRBS31_ENABLE != 0) && tx_prbs31_enable;

    lfsr_step #(
        .WIDTH (58),
        .TAP_A (SCR_TAP_A),
        .TAP_B (SCR_TAP_B),
        .NBITS (64),
        .MODE  (LFSR_SCRAMBLE)
    ) u_scrambler (
        .state_in  (scr_state),
        .data_in   (encoded_tx_data),
        .state_out (scr_next),
        .data_out  (scr_data)
    );

    if (PRBS31_ENABLE != 0) begin : g_prbs
        lfsr_step #(
            .WIDTH (31),
            .TAP_A (PRBS_TAP_A),
            .TAP_B (PRBS_TAP_B),
            .NBITS (66),
            .MODE  (LFSR_PRBS)
        ) u_prbs31 (
            .state_in  (prbs_state),
            .data_in   (66'd0),
            .state_out (prbs_next),
            .data_out  (prbs_bits)
        );
    end else begin : g_no_prbs
        assign prbs_next = prbs_state;
        assign prbs_bits = '0;
    end

    // PRBS stream order is hdr[0], hdr[1], data[0..63], matching wire order.
    always_comb begin
        beat_mux = '0;
        if (prbs_sel) begin
            beat_mux.hdr  = prbs_bits[1:0];
            beat_mux.data = prbs_bits[65:2];
            beat_mux.bad  = 1'b0;
        end else begin
            beat_mux.hdr  = encoded_tx_hdr;
            beat_mux.data = (SCRAMBLER_DISABLE != 0) ? encoded_tx_data : scr_data;
            beat_mux.bad  = hdr_is_bad(encoded_tx_hdr);
        end
    end

    always_comb begin
        beat_d = beat_mux;
        if (BIT_REVERSE != 0) begin
            for (int i = 0; i < 64; i++) beat_d.data[i] = beat_mux.data[63-i];
            beat_d.hdr = {beat_mux.hdr[0], beat_mux.hdr[1]};
        end
    end

    // Scrambler advances on every block, even in PRBS mode, so leaving PRBS needs no re-seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scr_state  <= SCRAMBLER_INIT;
            prbs_state <= PRBS31_INIT;
            beat_q     <= '0;
        end else begin
            scr_state <= (SCRAMBLER_DISABLE != 0) ? SCRAMBLER_INIT : scr_next;
            if (prbs_sel) prbs_state <= prbs_next;
            beat_q <= beat_d;
        end
    end

    if (SERDES_PIPELINE > 0) begin : g_pipe
        tx_beat_t pipe_q [1:SERDES_PIPELINE];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 1; i <= SERDES_PIPELINE; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[1] <= beat_q;
                for (int i = 2; i <= SERDES_PIPELINE; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign {tx_bad_block, serdes_tx_hdr, serdes_tx_data} = pipe_q[SERDES_PIPELINE];
    end else begin : g_no_pipe
        assign {tx_bad_block, serdes_tx_hdr, serdes_tx_data} = beat_q;
    end

endmodule

// File: tb/tb_eth_phy_10g_tx_if.sv
// Bench for eth_phy_10g_tx_if: passthrough, scrambled and bit-reversed/pipelined instances
// share one input stream; a scoreboard queue per instance holds the expected output.
module tb_eth_phy_10g_tx_if;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  hdr;
        logic        bad;
    } exp_t;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  hdr;
        logic        prbs;
    } stim_t;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  hdr;
        logic        bad;
        logic [63:0] rdata;
        logic [1:0]  rhdr;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] in_data;
    logic [1:0]  in_hdr;
    logic        prbs_en;

    logic [63:0] dis_data, scr_data, rev_data;
    logic [1:0]  dis_hdr, scr_hdr, rev_hdr;
    logic        dis_bad, scr_bad, rev_bad;

    exp_t        q_dis[$];
    exp_t        q_rev[$];
    stim_t       q_scr[$];
    logic [57:0] sc_state;
    logic [30:0] pr_hist;
    int          n_chk;
    int          n_fail;
    vec_t        tbl[6];

    eth_phy_10g_tx_if #(.SCRAMBLER_DISABLE(1)) u_dis (
        .clk(clk), .rst_n(rst_n), .encoded_tx_data(in_data), .encoded_tx_hdr(in_hdr),
        .serdes_tx_data(dis_data), .serdes_tx_hdr(dis_hdr), .tx_bad_block(dis_bad),
        .tx_prbs31_enable(prbs_en));

    eth_phy_10g_tx_if #(.PRBS31_ENABLE(1)) u_scr (
        .clk(clk), .rst_n(rst_n), .encoded_tx_data(in_data), .encoded_tx_hdr(in_hdr),
        .serdes_tx_data(scr_data), .serdes_tx_hdr(scr_hdr), .tx_bad_block(scr_bad),
        .tx_prbs31_enable(prbs_en));

    eth_phy_10g_tx_if #(.SCRAMBLER_DISABLE(1), .BIT_REVERSE(1), .SERDES_PIPELINE(3)) u_rev (
        .clk(clk), .rst_n(rst_n), .encoded_tx_data(in_data), .encoded_tx_hdr(in_hdr),
        .serdes_tx_data(rev_data), .serdes_tx_hdr(rev_hdr), .tx_bad_block(rev_bad),
        .tx_prbs31_enable(prbs_en));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic is_bad(input logic [1:0] h);
        return (h == 2'b00) || (h == 2'b11);
    endfunction

    function automatic logic [63:0] rev64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = d[63-i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bench_reset_state();
        q_dis.delete();
        q_rev.delete();
        q_scr.delete();
        sc_state = 58'h3FF_FFFF_FFFF_FFFF;
        pr_hist  = 31'h7FFF_FFFF;
        for (int i = 0; i < 3; i++) q_rev.push_back('{64'd0, 2'b00, 1'b0});
    endtask

    task automatic check_all();
        exp_t        e;
        stim_t       s;
        logic [63:0] d;
        logic [65:0] st;
        logic        x;
        logic        n;
        int          errs;
        e = q_dis.pop_front();
        chk("dis_out", {dis_bad, dis_hdr, dis_data}, {e.bad, e.hdr, e.data});
        e = q_rev.pop_front();
        chk("rev_out", {rev_bad, rev_hdr, rev_data}, {e.bad, e.hdr, e.data});
        s = q_scr.pop_front();
        if (s.prbs) begin
            errs = 0;
            st   = {scr_data, scr_hdr};
            for (int k = 0; k < 66; k++) begin
                n = pr_hist[30] ^ pr_hist[27];
                if (st[k] !== ~n) errs++;
                pr_hist = {pr_hist[29:0], ~st[k]};
            end
            // Track what the DUT scrambler does with the hidden input meanwhile.
            for (int j = 0; j < 64; j++) begin
                x = s.data[j] ^ sc_state[38] ^ sc_state[57];
                sc_state = {sc_state[56:0], x};
            end
            chk("prbs_bit_errors", 67'(errs), 67'd0);
            chk("prbs_bad_block", {66'd0, scr_bad}, 67'd0);
        end else begin
            for (int j = 0; j < 64; j++) begin
                x = scr_data[j];
                d[j] = x ^ sc_state[38] ^ sc_state[57];
                sc_state = {sc_state[56:0], x};
            end
            chk("scr_descrambled", {3'd0, d}, {3'd0, s.data});
            chk("scr_hdr_bad", {64'd0, scr_bad, scr_hdr}, {64'd0, is_bad(s.hdr), s.hdr});
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic drive(input logic [63:0] d, input logic [1:0] h, input logic p,
                         input exp_t e_dis, input exp_t e_rev);
        in_data = d;
        in_hdr  = h;
        prbs_en = p;
        q_dis.push_back(e_dis);
        q_rev.push_back(e_rev);
        q_scr.push_back('{d, h, p});
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic drive_auto(input logic [63:0] d, input logic [1:0] h, input logic p);
        drive(d, h, p, '{d, h, is_bad(h)}, '{rev64(d), {h[0], h[1]}, is_bad(h)});
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_dis"}, {dis_bad, dis_hdr, dis_data}, 67'd0);
        chk({tag, "_scr"}, {scr_bad, scr_hdr, scr_data}, 67'd0);
        chk({tag, "_rev"}, {rev_bad, rev_hdr, rev_data}, 67'd0);
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        in_data = '0;
        in_hdr  = 2'b00;
        prbs_en = 1'b0;
        rst_n   = 1'b1;

        tbl[0] = '{64'h0123_4567_89AB_CDEF, 2'b01, 1'b0, 64'hF7B3_D591_E6A2_C480, 2'b10};
        tbl[1] = '{64'h0000_0000_0000_0000, 2'b00, 1'b1, 64'h0000_0000_0000_0000, 2'b00};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11};
        tbl[3] = '{64'h0000_0000_0000_0001, 2'b01, 1'b0, 64'h8000_0000_0000_0000, 2'b10};
        tbl[4] = '{64'h0000_0000_FFFF_FFFF, 2'b10, 1'b0, 64'hFFFF_FFFF_0000_0000, 2'b01};
        tbl[5] = '{64'h8000_0000_0000_0000, 2'b10, 1'b0, 64'h0000_0000_0000_0001, 2'b01};

        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("reset");
        bench_reset_state();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // First scrambled block of zeros from the reset seed.
        drive_auto(64'd0, 2'b10, 1'b0);
        chk("scr_first_block", {27'd0, scr_hdr, scr_data[39:0]}, {27'd0, 2'b10, 40'h80_0000_0000});

        // Table: passthrough, illegal headers 00/11 then 01, bit-reverse corners.
        for (int i = 0; i < 6; i++)
            drive(tbl[i].data, tbl[i].hdr, 1'b0, '{tbl[i].data, tbl[i].hdr, tbl[i].bad},
                  '{tbl[i].rdata, tbl[i].rhdr, tbl[i].bad});

        for (int i = 0; i < 1000; i++)
            drive_auto({$urandom(), $urandom()}, 2'($urandom_range(0, 3)), 1'b0);

        for (int i = 0; i < 10000; i++)
            drive_auto({$urandom(), $urandom()}, 2'($urandom_range(0, 3)), 1'b1);

        for (int i = 0; i < 50; i++)
            drive_auto({$urandom(), $urandom()}, 2'($urandom_range(1, 2)), 1'b0);

        // Asynchronous reset between clock edges, mid-stream.
        for (int i = 0; i < 3; i++) drive_auto({$urandom(), $urandom()}, 2'b01, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_zero_outputs("async_reset");
        bench_reset_state();
        in_data = '0;
        in_hdr  = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive_auto(64'd0, 2'b10, 1'b0);
        chk("scr_after_reset", {27'd0, scr_hdr, scr_data[39:0]}, {27'd0, 2'b10, 40'h80_0000_0000});
        for (int i = 0; i < 8; i++) drive_auto({$urandom(), $urandom()}, 2'b10, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
